drp_clock_reconfig: RTL

//  Parametrised, re-triggerable DRP sequencer for the global-controller clock DCM. Takes a divider over the conf bus.

---
 rtl/drp_clock_reconfig.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/drp_clock_reconfig.sv
// Re-triggerable DRP sequencer for the DCM: read-modify-write over a register table with
// the DCM held in reset, then release and wait for lock, with timeouts and error codes.
module drp_clock_reconfig #(
  parameter int DATA_WIDTH   = 8,
  parameter int SELECT_WIDTH = 3,
  parameter logic [SELECT_WIDTH-1:0] SEL_ID = 3'b001,
  parameter int D_ADDRESS    = 7,
  parameter int D_DATA       = 16,
  parameter int NUM_REGS     = 3,
  parameter logic [NUM_REGS*D_ADDRESS-1:0] REG_ADDR = {7'h51, 7'h41, 7'h50},
  parameter logic [NUM_REGS*D_DATA-1:0]    REG_KEEP = {16'hFFF3, 16'hFFFB, 16'h0000},
  parameter int MAX_DIV      = 8,
  parameter int DRDY_TIMEOUT = 255,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                    dclk_in,
  input  logic                    reset_n,
  input  logic [DATA_WIDTH-1:0]   conf_bus,
  input  logic [SELECT_WIDTH-1:0] sel,
  input  logic                    conf_valid,
  output logic                    conf_ready,
  output logic                    busy,
  output logic                    locked_out,
  output logic                    err,
  output logic [1:0]              err_code,
  output logic [DATA_WIDTH-1:0]   cur_div,
  output logic                    rst_dcm,
  output logic                    den,
  output logic                    dwe,
  output logic [D_ADDRESS-1:0]    daddr,
  output logic [D_DATA-1:0]       di,
  input  logic [D_DATA-1:0]       dout,
  input  logic                    drdy,
  input  logic                    dcm_locked
);

  localparam int DW = $clog2(DRDY_TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ_REQ, S_READ_WAIT, S_MODIFY,
    S_WRITE_REQ, S_WRITE_WAIT, S_RELEASE, S_WAIT_LOCK
  } state_t;

  state_t                  state, state_d;
  logic [1:0]              step;
  logic [DATA_WIDTH-1:0]   div;
  logic [D_DATA-1:0]       dout_cap;
  logic [DW-1:0]           drdy_cnt;
  logic [LW-1:0]           lock_cnt;
  logic                    lock_q;

  logic [D_ADDRESS-1:0]    addr_tbl [4];
  logic [D_DATA-1:0]       keep_tbl [4];
  logic [DATA_WIDTH-1:0]   req_div;
  logic                    accept, bad_div, drdy_to, lock_to, last_step;
  logic [7:0]              md_lo;
  logic [15:0]             md_full;
  logic [D_DATA-1:0]       md;

  // Tables padded to four entries so a 2-bit step never indexes past the end.
  for (genvar gi = 0; gi < 4; gi++) begin : g_tbl
    if (gi < NUM_REGS) begin : g_used
      assign addr_tbl[gi] = REG_ADDR[gi*D_ADDRESS +: D_ADDRESS];
      assign keep_tbl[gi] = REG_KEEP[gi*D_DATA +: D_DATA];
    end else begin : g_pad
      assign addr_tbl[gi] = '0;
      assign keep_tbl[gi] = '0;
    end
  end

  assign conf_ready = (state == S_IDLE);
  assign busy       = ~conf_ready;
  assign accept     = conf_ready && conf_valid && (sel == SEL_ID);
  assign req_div    = (conf_bus == '0) ? DATA_WIDTH'(1) : conf_bus;
  assign bad_div    = req_div > DATA_WIDTH'(MAX_DIV);
  assign drdy_to    = (drdy_cnt == DW'(DRDY_TIMEOUT - 1));
  assign lock_to    = (lock_cnt == LW'(LOCK_TIMEOUT - 1));
  assign last_step  = (step == 2'(NUM_REGS - 1));
  assign md_lo      = 8'({div, 1'b0} - {{DATA_WIDTH{1'b0}}, 1'b1});
  assign md_full    = {8'h01, md_lo};
  assign md         = D_DATA'(md_full);

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:       if (accept && !bad_div) state_d = S_READ_REQ;
      S_READ_REQ:   state_d = S_READ_WAIT;
      S_READ_WAIT:  if (drdy) state_d = S_MODIFY;
                    else if (drdy_to) state_d = S_IDLE;
      S_MODIFY:     state_d = S_WRITE_REQ;
      S_WRITE_REQ:  state_d = S_WRITE_WAIT;
      S_WRITE_WAIT: if (drdy) state_d = last_step ? S_RELEASE : S_READ_REQ;
                    else if (drdy_to) state_d = S_IDLE;
      S_RELEASE:    state_d = S_WAIT_LOCK;
      S_WAIT_LOCK:  if (lock_q || lock_to) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge dclk_in) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      rst_dcm    <= 1'b1;
      den        <= 1'b0;
      dwe        <= 1'b0;
      daddr      <= '0;
      di         <= '0;
      locked_out <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
      cur_div    <= '0;
      div        <= '0;
      step       <= '0;
      dout_cap   <= '0;
      drdy_cnt   <= '0;
      lock_cnt   <= '0;
      lock_q     <= 1'b0;
    end else begin
      state  <= state_d;
      lock_q <= dcm_locked;
      den    <= 1'b0;
      dwe    <= 1'b0;
      case (state)
        S_IDLE: begin
          // Tracks live lock after a pass; stays low while the DCM is held in reset.
          locked_out <= lock_q & ~rst_dcm;
          if (accept) begin
            if (bad_div) begin
              err      <= 1'b1;
              err_code <= 2'b11;
            end else begin
              err        <= 1'b0;
              err_code   <= 2'b00;
              locked_out <= 1'b0;
              rst_dcm    <= 1'b1;
              step       <= '0;
              div        <= req_div;
            end
          end
        end
        S_READ_REQ: begin
          den      <= 1'b1;
          daddr    <= addr_tbl[step];
          drdy_cnt <= '0;
        end
        S_READ_WAIT: begin
          if (drdy) dout_cap <= dout;
          else if (drdy_to) begin
            err      <= 1'b1;
            err_code <= 2'b01;
          end else drdy_cnt <= drdy_cnt + DW'(1);
        end
        S_MODIFY: di <= (dout_cap & keep_tbl[step]) | ((step == 2'd0) ? md : '0);
        S_WRITE_REQ: begin
          den      <= 1'b1;
          dwe      <= 1'b1;
          daddr    <= addr_tbl[step];
          drdy_cnt <= '0;
        end
        S_WRITE_WAIT: begin
          if (drdy) step <= step + 2'd1;
          else if (drdy_to) begin
            err      <= 1'b1;
            err_code <= 2'b01;
          end else drdy_cnt <= drdy_cnt + DW'(1);
        end
        S_RELEASE: begin
          rst_dcm  <= 1'b0;
          lock_cnt <= '0;
        end
        S_WAIT_LOCK: begin
          if (lock_q) begin
            locked_out <= 1'b1;
            cur_div    <= div;
          end else if (lock_to) begin
            err      <= 1'b1;
            err_code <= 2'b10;
            rst_dcm  <= 1'b1;
          end else lock_cnt <= lock_cnt + LW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
